aes_encrypt_iter: RTL and testbench
===================================

# aes_encrypt_iter

- Iterative, clocked AES encryption core; successor to the fully unrolled combinational encryptor.
- Parametrised for AES-128/192/256 via `NK`.
- Builds the key schedule one word per cycle into an internal store and reuses it across blocks until a new key is supplied.
- Runs one cipher round per cycle behind valid/ready handshakes on both sides; sits between a block source (e.g. mode-of-operation controller) and a ciphertext sink.

## Interface

Parameters:
- `NK` — default 4 — key length in 32-bit words; legal values 4, 6, 8.
- `NR` — default `NK+6` — round count; derived, not overridden.

Ports:
- `clk` — in, 1 — sole clock, rising edge.
- `rst_n` — in, 1 — asynchronous, active-low reset.
- `in_valid` — in, 1 — block/key offered.
- `in_ready` — out, 1 — core can accept a block.
- `in_data` — in, 128 — plaintext; `[127:120]` is byte 0 (FIPS-197 order).
- `in_key` — in, `32*NK` — cipher key; MSB word is w[0].
- `in_new_key` — in, 1 — expand `in_key` for this block; otherwise the stored schedule is reused.
- `out_valid` — out, 1 — ciphertext available.
- `out_ready` — in, 1 — sink accepts the ciphertext.
- `out_data` — out, 128 — ciphertext, same byte order as `in_data`.
- `busy` — out, 1 — state is not IDLE.

## Operation

States and transitions:
- **IDLE**: `in_ready`=1. On accept (`in_valid && in_ready`), capture `in_data` into the state register and `in_key` into key words 0..NK-1.
  - Go to KEYGEN if `in_new_key`=1 or `sched_ok`=0.
  - Otherwise go to ROUND.
- **KEYGEN**: one word per cycle, i = NK .. 4(NR+1)-1.
  - temp = w[i-1].
  - If i%NK==0: temp = SubWord(RotWord(temp)) ^ {rcon,24'h0}, then rcon = xtime(rcon).
  - Else if NK==8 and i%8==4: temp = SubWord(temp).
  - w[i] = w[i-NK] ^ temp.
  - rcon resets to 8'h01 on KEYGEN entry.
  - After the last word, set `sched_ok`=1 and go to ROUND.
- **ROUND**: round counter r = 0..NR, one per cycle.
  - r=0: state ^= rk0.
  - 1 ≤ r < NR: SubBytes, ShiftRows, MixColumns, AddRoundKey(rk_r).
  - r=NR: skip MixColumns.
  - Then go to DONE.
- **DONE**: `out_valid`=1 and `out_data`=state. Both hold stable until `out_ready`; then go to IDLE.

Rules:
- `in_ready`=1 only in IDLE. There is no overlap between the output hold and the next accept.
- `in_key` and `in_new_key` are sampled only at accept. Changes at any other time are ignored.
- Key words are not rewritten when `in_new_key`=0 and `sched_ok`=1, so `in_key` is a don't-care in that case.
- Round key rk_r = {w[4r], w[4r+1], w[4r+2], w[4r+3]}.

## Timing

Reset values (asynchronous):
- State = IDLE.
- `in_ready`=1, `out_valid`=0, `busy`=0, `out_data`=0.
- `sched_ok`=0; round and word counters = 0.
- Key store contents are not reset.
- Reset asserted mid-KEYGEN or mid-ROUND aborts the operation. The next block must re-expand because `sched_ok` is cleared.

Latency, accept edge (cycle 0) to first `out_valid` cycle:
- Key reused: NR+2 cycles.
  - NK=4: 12; NK=6: 14; NK=8: 16.
- New key: adds 4(NR+1)-NK KEYGEN cycles.
  - NK=4: 40+12=52; NK=6: 46+14=60; NK=8: 52+16=68.

Other timing rules:
- Minimum spacing between accepts with key reuse, `out_ready` tied high: NR+3 cycles.
- `in_new_key`=0 on the first block after reset is forced to a KEYGEN pass, with no error flag.
- `out_ready` high in the same cycle `out_valid` first rises completes the transfer in that cycle. `in_ready` rises on the next cycle.
- Round counter width: $clog2(NR+1). Word counter width: 6 bits.

## Structure

Shared package `aes_pkg`:
- S-box function.
- `xtime` / `mb2` / `mb3` GF helpers.
- RotWord and SubWord functions.
- State-enum typedef.

Sub-module `aes_key_sched`:
- Owns the word store 4(NR+1)×32, the word counter, rcon and `sched_ok`.
- Read port indexed by round number.

Round datapath:
- Reuses the existing subBytes, shiftRows, mixColumns and addRoundKey modules.
- A final-round mux bypasses mixColumns.

## Test plan

1. **NK=4, FIPS-197 App. B, `in_new_key`=1.**
   - Stimulus: key 2b7e151628aed2a6abf7158809cf4f3c, pt 3243f6a8885a308d313198a2e0370734.
   - Required: `out_data`=3925841d02dc09fbdc118597196a0b32, `out_valid` 52 cycles after accept.
2. **NK=4 key reuse.**
   - Stimulus: send pt 00112233445566778899aabbccddeeff with `in_new_key`=0, key 000102…0f previously loaded.
   - Required: 69c4e0d86a7b0430d8cdb78070b4c55a after 12 cycles.
   - Also: garbage on `in_key` must not change the result.
3. **NK=6 and NK=8, FIPS-197 App. C.**
   - Stimulus: same pt; keys 00…17 and 00…1f.
   - Required: dda97ca4864cdfe06eaf70a0ec0d7191 at 60 cycles; 8ea2b7ca516745bfeafc49904b496089 at 68 cycles.
4. **Backpressure.**
   - Stimulus: hold `out_ready`=0 for 20 cycles after `out_valid`.
   - Required: `out_data` stable; `in_ready`=0 and `in_valid` ignored throughout; a single transfer on release.
5. **Reset mid-ROUND.**
   - Stimulus: assert `rst_n`=0 at round 5 of case 2.
   - Required: outputs at reset values immediately.
   - Then: the next block with `in_new_key`=0 still takes 52 cycles and gives the correct ciphertext.
6. **First-after-reset.**
   - Stimulus: `in_new_key`=0 on the first block.
   - Required: forced KEYGEN, correct ciphertext at 52 cycles (NK=4).

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES helpers for the iterative encryptor.
//   - aes_state_e : controller state encoding
//   - sbox        : forward S-box lookup
//   - xtime/mb2/mb3 : GF(2^8) multiply-by-2 and multiply-by-3
//   - rot_word / sub_word : key-expansion word operations
//   - mix_col     : MixColumns applied to one 32-bit column (row 0 in MSB)
package aes_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_KEYGEN,
    S_ROUND,
    S_DONE
  } aes_state_e;

  // Forward S-box, entry 0 in the most significant byte.
  localparam logic [2047:0] SBOX_FLAT = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    logic [10:0] hi;
    // Top bit of entry b is 8*(255-b)+7, and 255-b is ~b for a byte.
    hi = {~b, 3'b111};
    return SBOX_FLAT[hi -: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] mb2(input logic [7:0] b);
    return xtime(b);
  endfunction

  function automatic logic [7:0] mb3(input logic [7:0] b);
    return xtime(b) ^ b;
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [31:0] mix_col(input logic [31:0] w);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = w;
    return {mb2(a0) ^ mb3(a1) ^ a2      ^ a3,
            a0      ^ mb2(a1) ^ mb3(a2) ^ a3,
            a0      ^ a1      ^ mb2(a2) ^ mb3(a3),
            mb3(a0) ^ a1      ^ a2      ^ mb2(a3)};
  endfunction

endpackage

// File: rtl/aes_key_sched.sv
// Iterative AES key expansion with a persistent word store.
//   load     : write key into w[0..NK-1], restart expansion, drop sched_ok
//   step     : generate the next word w[widx]
//   key      : cipher key, MSB word is w[0]
//   rd_round : round number for the round-key read port
//   rk       : {w[4r], w[4r+1], w[4r+2], w[4r+3]}
//   sched_ok : full schedule present in the store
//   last     : the word generated this cycle is the final one
module aes_key_sched
  import aes_pkg::*;
#(
  parameter  int NK = 4,
  localparam int NR = NK + 6,
  localparam int NW = 4 * (NR + 1),
  localparam int RW = $clog2(NR + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              step,
  input  logic [32*NK-1:0]  key,
  input  logic [RW-1:0]     rd_round,
  output logic [127:0]      rk,
  output logic              sched_ok,
  output logic              last
);

  logic [31:0] w [NW];
  logic [5:0]  widx;
  logic [2:0]  wmod;   // widx mod NK, kept as a counter to avoid a divider
  logic [7:0]  rcon;
  logic [31:0] prev, temp, nw;
  logic [5:0]  rb;

  always_comb begin
    prev = w[widx - 6'd1];
    temp = prev;
    if (wmod == 3'd0)
      temp = sub_word(rot_word(prev)) ^ {rcon, 24'h0};
    else if (NK == 8 && wmod == 3'd4)
      temp = sub_word(prev);
    nw = w[widx - 6'(NK)] ^ temp;
  end

  assign last = (widx == 6'(NW - 1));

  assign rb = 6'({rd_round, 2'b00});
  assign rk = {w[rb], w[rb + 6'd1], w[rb + 6'd2], w[rb + 6'd3]};

  // Word store carries no reset; sched_ok guards its validity.
  always_ff @(posedge clk) begin
    if (load) begin
      for (int k = 0; k < NK; k++) w[k] <= key[32*(NK-1-k) +: 32];
    end else if (step) begin
      w[widx] <= nw;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      widx     <= '0;
      wmod     <= '0;
      rcon     <= 8'h01;
      sched_ok <= 1'b0;
    end else if (load) begin
      widx     <= 6'(NK);
      wmod     <= '0;
      rcon     <= 8'h01;
      sched_ok <= 1'b0;
    end else if (step) begin
      widx <= widx + 6'd1;
      wmod <= (wmod == 3'(NK - 1)) ? 3'd0 : wmod + 3'd1;
      if (wmod == 3'd0) rcon <= xtime(rcon);
      if (last) sched_ok <= 1'b1;
    end
  end

endmodule

// File: rtl/aes_round.sv
// One AES cipher round, purely combinational.
//   state : current state (byte 0 in [127:120], column-major)
//   rk    : round key for this round
//   first : initial AddRoundKey only
//   last  : final round, MixColumns bypassed
//   nxt   : state after the round
module aes_round
  import aes_pkg::*;
(
  input  logic [127:0] state,
  input  logic [127:0] rk,
  input  logic         first,
  input  logic         last,
  output logic [127:0] nxt
);

  logic [127:0] sb, sr, mc;

  always_comb begin
    sb  = '0;
    sr  = '0;
    mc  = '0;
    nxt = '0;
    for (int k = 0; k < 16; k++) sb[8*k +: 8] = sbox(state[8*k +: 8]);
    // Byte (row r, col c) sits at index 4c+r; row r rotates left by r columns.
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        sr[127-8*(4*c+r) -: 8] = sb[127-8*(4*((c+r)%4)+r) -: 8];
    for (int c = 0; c < 4; c++) mc[32*c +: 32] = mix_col(sr[32*c +: 32]);
    if (first)     nxt = state ^ rk;
    else if (last) nxt = sr ^ rk;
    else           nxt = mc ^ rk;
  end

endmodule

// File: rtl/aes_encrypt_iter.sv
// Iterative AES-128/192/256 encryptor, one round per cycle.
//   clk, rst_n         : clock, async active-low reset
//   in_valid/in_ready  : block handshake (accepted only in IDLE)
//   in_data            : plaintext, byte 0 in [127:120]
//   in_key/in_new_key  : key and expand request, sampled at accept only
//   out_valid/out_ready: ciphertext handshake, held until taken
//   out_data           : ciphertext
//   busy               : controller not in IDLE
module aes_encrypt_iter
  import aes_pkg::*;
#(
  parameter  int NK = 4,
  localparam int NR = NK + 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [127:0]      in_data,
  input  logic [32*NK-1:0]  in_key,
  input  logic              in_new_key,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [127:0]      out_data,
  output logic              busy
);

  localparam int RW = $clog2(NR + 1);

  aes_state_e   st;
  logic [127:0] state, round_out, rk;
  logic [RW-1:0] rnd;
  logic         sched_ok, ks_last, need_key, accept, ks_load, ks_step;

  assign accept   = (st == S_IDLE) && in_valid;
  // A missing schedule (first block after reset) forces expansion.
  assign need_key = in_new_key || !sched_ok;
  assign ks_load  = accept && need_key;
  assign ks_step  = (st == S_KEYGEN);

  aes_key_sched #(.NK(NK)) u_ks (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (ks_load),
    .step     (ks_step),
    .key      (in_key),
    .rd_round (rnd),
    .rk       (rk),
    .sched_ok (sched_ok),
    .last     (ks_last)
  );

  aes_round u_round (
    .state (state),
    .rk    (rk),
    .first (rnd == '0),
    .last  (rnd == RW'(NR)),
    .nxt   (round_out)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st        <= S_IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      out_data  <= '0;
      state     <= '0;
      rnd       <= '0;
    end else begin
      case (st)
        S_IDLE: if (accept) begin
          state    <= in_data;
          rnd      <= '0;
          in_ready <= 1'b0;
          busy     <= 1'b1;
          st       <= need_key ? S_KEYGEN : S_ROUND;
        end
        S_KEYGEN: if (ks_last) st <= S_ROUND;
        S_ROUND: begin
          state <= round_out;
          if (rnd == RW'(NR)) begin
            st        <= S_DONE;
            out_valid <= 1'b1;
            out_data  <= round_out;
          end else begin
            rnd <= rnd + 1'b1;
          end
        end
        S_DONE: if (out_ready) begin
          st        <= S_IDLE;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          busy      <= 1'b0;
        end
        default: st <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_encrypt_iter.sv
// Directed bench for aes_encrypt_iter with FIPS-197 vectors across NK=4/6/8.
// Latency is counted with the accept cycle as cycle 0, so the first cycle
// showing out_valid after NR+1 further edges reads as NR+2.
module tb_aes_encrypt_iter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [127:0] pt;
  logic         nk, ordy;
  logic         iv4, iv6, iv8, ir4, ir6, ir8, ov4, ov6, ov8, bz4, bz6, bz8;
  logic [127:0] k4, od4, od6, od8;
  logic [191:0] k6;
  logic [255:0] k8;

  aes_encrypt_iter #(.NK(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(ir4), .in_data(pt),
    .in_key(k4), .in_new_key(nk), .out_valid(ov4), .out_ready(ordy),
    .out_data(od4), .busy(bz4));
  aes_encrypt_iter #(.NK(6)) dut6 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv6), .in_ready(ir6), .in_data(pt),
    .in_key(k6), .in_new_key(nk), .out_valid(ov6), .out_ready(ordy),
    .out_data(od6), .busy(bz6));
  aes_encrypt_iter #(.NK(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .in_data(pt),
    .in_key(k8), .in_new_key(nk), .out_valid(ov8), .out_ready(ordy),
    .out_data(od8), .busy(bz8));

  localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [255:0] KEY_B = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [255:0] KEY_C = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [255:0] KEY_J = 256'hdeadbeef_cafef00d_0badc0de_12345678_9abcdef0_55aa55aa_ffffffff_a5a5a5a5;
  localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] CT_4  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT_6  = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [127:0] CT_8  = 128'h8ea2b7ca516745bfeafc49904b496089;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  function automatic logic rdy(input int id);
    case (id)
      4:       return ir4;
      6:       return ir6;
      default: return ir8;
    endcase
  endfunction

  function automatic logic ovl(input int id);
    case (id)
      4:       return ov4;
      6:       return ov6;
      default: return ov8;
    endcase
  endfunction

  function automatic logic [127:0] odat(input int id);
    case (id)
      4:       return od4;
      6:       return od6;
      default: return od8;
    endcase
  endfunction

  // Offer one block; returns 1ns after the accept edge with inputs scrambled
  // so that anything sampled outside the accept edge would corrupt results.
  task automatic send(input int id, input logic [127:0] d, input logic [255:0] key,
                      input logic newk, input string tag);
    @(negedge clk);
    chk({tag, "/in_ready"}, rdy(id), 1'b1);
    pt = d;
    nk = newk;
    k4 = key[255:128];
    k6 = key[255:64];
    k8 = key;
    case (id)
      4:       iv4 = 1'b1;
      6:       iv6 = 1'b1;
      default: iv8 = 1'b1;
    endcase
    @(posedge clk);
    #1;
    iv4 = 1'b0; iv6 = 1'b0; iv8 = 1'b0;
    pt = ~d;
    nk = ~newk;
    k4 = ~k4; k6 = ~k6; k8 = ~k8;
  endtask

  task automatic wait_out(input int id, input logic [127:0] exp, input int exp_lat,
                          input logic drain, input string tag);
    int n = 0;
    while (!ovl(id) && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk({tag, "/latency"}, 128'(n + 1), 128'(exp_lat));
    chk({tag, "/data"}, odat(id), exp);
    if (drain) begin
      @(posedge clk);
      #1;
      chk({tag, "/valid_drop"}, ovl(id), 1'b0);
      chk({tag, "/ready_back"}, rdy(id), 1'b1);
    end
  endtask

  initial begin
    int bad;
    logic [127:0] held;
    iv4 = 0; iv6 = 0; iv8 = 0;
    pt = '0; nk = 0; ordy = 1'b1;
    k4 = '0; k6 = '0; k8 = '0;

    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("reset/in_ready",  ir4, 1'b1);
    chk("reset/out_valid", ov4, 1'b0);
    chk("reset/busy",      bz4, 1'b0);
    chk("reset/out_data",  od4, 128'h0);

    // First block after reset with in_new_key=0 must still expand the key.
    send(4, PT_C, KEY_C, 1'b0, "first_after_reset");
    wait_out(4, CT_4, 52, 1'b1, "first_after_reset");

    // Stored schedule reused; junk on in_key is ignored.
    send(4, PT_C, KEY_J, 1'b0, "reuse");
    wait_out(4, CT_4, 12, 1'b1, "reuse");

    // New key, FIPS-197 Appendix B.
    send(4, PT_B, KEY_B, 1'b1, "appb");
    wait_out(4, CT_B, 52, 1'b1, "appb");

    // Reload the Appendix C key explicitly.
    send(4, PT_C, KEY_C, 1'b1, "reload");
    wait_out(4, CT_4, 52, 1'b1, "reload");

    // Backpressure: hold the result while the source keeps offering.
    ordy = 1'b0;
    send(4, PT_C, KEY_J, 1'b0, "bp");
    wait_out(4, CT_4, 12, 1'b0, "bp");
    held = od4;
    bad = 0;
    iv4 = 1'b1;
    pt  = PT_B;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk);
      #1;
      if (od4 !== held || ir4 !== 1'b0 || ov4 !== 1'b1) bad++;
    end
    chk("bp/hold_violations", 128'(bad), 128'h0);
    iv4  = 1'b0;
    ordy = 1'b1;
    @(posedge clk);
    #1;
    chk("bp/valid_drop", ov4, 1'b0);
    chk("bp/ready_back", ir4, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    chk("bp/single_xfer_busy",  bz4, 1'b0);
    chk("bp/single_xfer_valid", ov4, 1'b0);

    // Reset in the middle of ROUND, round counter at 5.
    send(4, PT_C, KEY_J, 1'b0, "rst_mid");
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("rst_mid/in_ready",  ir4, 1'b1);
    chk("rst_mid/out_valid", ov4, 1'b0);
    chk("rst_mid/busy",      bz4, 1'b0);
    chk("rst_mid/out_data",  od4, 128'h0);
    #10;
    rst_n = 1'b1;
    send(4, PT_C, KEY_C, 1'b0, "after_rst");
    wait_out(4, CT_4, 52, 1'b1, "after_rst");

    // AES-192 and AES-256, FIPS-197 Appendix C.
    send(6, PT_C, KEY_C, 1'b1, "aes192");
    wait_out(6, CT_6, 60, 1'b1, "aes192");
    send(8, PT_C, KEY_C, 1'b1, "aes256");
    wait_out(8, CT_8, 68, 1'b1, "aes256");
    send(8, PT_C, KEY_J, 1'b0, "aes256_reuse");
    wait_out(8, CT_8, 16, 1'b1, "aes256_reuse");

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end

endmodule
